// File: rtl/pmod_i2c_target.sv
// pmod_i2c_target: I2C target front-end with a byte-wide register file.
//
// Ports:
//   clk, rst_n   system clock (>= 16x SCL) and async active-low reset
//   scl_i, sda_i raw bus pin levels (synchronized internally)
//   sda_oe       1 = pull SDA low (open drain, never drives high)
//   in_port      read-only byte returned for register index 0
//   regs_o       flattened register file, index i at [8i+7:8i]; index 0 reads 0
//   wr_stb       one-cycle pulse per committed register write
//   wr_idx       index of that write, valid while wr_stb is high
//   busy         high from an ACKed address until STOP or read NACK
//
// Access pattern: [S addr+W ptr data...] auto-incrementing burst writes,
// [S addr+W ptr Sr addr+R data...] auto-incrementing burst reads.
module pmod_i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h18,
    parameter int         NREGS       = 16,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    input  logic [7:0]               in_port,
    output logic [8*NREGS-1:0]       regs_o,
    output logic                     wr_stb,
    output logic [$clog2(NREGS)-1:0] wr_idx,
    output logic                     busy
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WACK, S_RDATA, S_RACK
    } state_e;

    // ---------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer plus one history flop.
    // Reset to 1 so an idle bus produces no spurious edges.
    // ---------------------------------------------------------------
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
            sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
            sda_s1_q <= sda_i; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q &  scl_h_q;
    // SDA edges only count as START/STOP while SCL is stably high.
    assign start_det =  scl_s2_q & scl_h_q &  sda_h_q & ~sda_s2_q;
    assign stop_det  =  scl_s2_q & scl_h_q & ~sda_h_q &  sda_s2_q;

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    state_e          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic            phase_q, phase_d;   // 0: before ACK clock, 1: inside it
    logic            rw_q, rw_d;
    logic [7:0]      shin_q, shin_d;
    logic [7:0]      shout_q, shout_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            wr_stb_q, wr_stb_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic            wr_commit;
    logic [7:0]      regs_q [NREGS];

    logic [7:0] byte_in;
    logic       last_bit;
    logic [7:0] rd_byte;
    assign byte_in  = {shin_q[6:0], sda_s2_q};
    assign last_bit = (bitcnt_q == 3'd7);
    // Index 0 is the input port on reads; its storage slot is never written.
    assign rd_byte  = (ptr_q == '0) ? in_port : regs_q[ptr_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_IDLE:     state_d = S_IDLE;
                S_ADDR:     if (scl_rise && last_bit)
                                state_d = (byte_in[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (scl_fall && phase_q)
                                state_d = rw_q ? S_RDATA : S_PTR;
                S_PTR:      if (scl_rise && last_bit) state_d = S_PTR_ACK;
                S_PTR_ACK:  if (scl_fall && phase_q)  state_d = S_WDATA;
                S_WDATA:    if (scl_rise && last_bit) state_d = S_WACK;
                S_WACK:     if (scl_fall && phase_q)  state_d = S_WDATA;
                S_RDATA:    if (scl_fall && last_bit) state_d = S_RACK;
                S_RACK: begin
                    if (!phase_q && scl_rise && sda_s2_q) state_d = S_IDLE;
                    else if (phase_q && scl_fall)         state_d = S_RDATA;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next-state logic. sda_oe only moves on a synced
    // SCL fall, except START/STOP which release the line immediately.
    always_comb begin
        bitcnt_d  = bitcnt_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        shin_d    = shin_q;
        shout_d   = shout_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_commit = 1'b0;
        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shin_d   = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b0;
                            if (state_q == S_ADDR) rw_d  = sda_s2_q;
                            if (state_q == S_PTR)  ptr_d = byte_in[IW-1:0];
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                            if (state_q == S_ADDR_ACK) busy_d = 1'b1;
                            if (state_q == S_WACK) begin
                                wr_commit = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_idx_d  = ptr_q;
                                ptr_d     = ptr_q + IW'(1);
                            end
                        end else begin
                            bitcnt_d = '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                shout_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                        end else begin
                            shout_d  = {shout_q[6:0], 1'b0};
                            sda_oe_d = ~shout_q[6];
                        end
                    end
                end
                S_RACK: begin
                    if (!phase_q && scl_rise) begin
                        ptr_d = ptr_q + IW'(1);
                        if (sda_s2_q) busy_d  = 1'b0;  // master NACK ends the read
                        else          phase_d = 1'b1;
                    end else if (phase_q && scl_fall) begin
                        // Pointer already advanced; in_port sampled here.
                        shout_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        bitcnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q <= '0;
            phase_q  <= 1'b0;
            rw_q     <= 1'b0;
            shin_q   <= '0;
            shout_q  <= '0;
            ptr_q    <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_idx_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            rw_q     <= rw_d;
            shin_q   <= shin_d;
            shout_q  <= shout_d;
            ptr_q    <= ptr_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            wr_stb_q <= wr_stb_d;
            wr_idx_q <= wr_idx_d;
            if (wr_commit && ptr_q != '0) regs_q[ptr_q] <= shin_q;
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = busy_q;
    assign wr_stb = wr_stb_q;
    assign wr_idx = wr_idx_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        if (g == 0) begin : g_zero
            assign regs_o[7:0] = 8'h00;
        end else begin : g_reg
            assign regs_o[8*g +: 8] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_pmod_i2c_target.sv
module tb_pmod_i2c_target;
    localparam int NREGS = 16;
    localparam int Q     = 8;   // clk cycles per SCL quarter period

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic [7:0]   in_port = 8'h00;
    logic         sda_oe, wr_stb, busy;
    logic [127:0] regs_o;
    logic [3:0]   wr_idx;
    logic         sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    pmod_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .in_port(in_port), .regs_o(regs_o),
        .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- monitors (sole writers of their variables) ----
    int       wr_n = 0;
    int       wr_log [1024];
    int       oe_cnt = 0, busy_cnt = 0, viol = 0;
    logic     tchk_en = 1'b1;
    logic     oe_prev = 1'b0;
    logic [2:0] scl_hist = 3'b000;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_log[wr_n % 1024] <= int'(wr_idx);
            wr_n <= wr_n + 1;
        end
        if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        // sda_oe must not move while SCL has been high for a while
        if (tchk_en && rst_n && sda_oe !== oe_prev && scl_hist == 3'b111) viol <= viol + 1;
        oe_prev  <= sda_oe;
        scl_hist <= {scl_hist[1:0], scl_m};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---- reference model: byte-level register file and pointer ----
    logic [7:0] mdl [NREGS];
    int         mptr;
    int         exp_idx [$];
    int         wr_rd = 0;
    logic [7:0] wbuf [8];

    function automatic logic [127:0] flat();
        logic [127:0] r = '0;
        for (int i = 1; i < NREGS; i++) r[8*i +: 8] = mdl[i];
        return r;
    endfunction

    task automatic chk_wr();
        chk("wr_cnt", 128'(wr_n - wr_rd), 128'(exp_idx.size()));
        while (wr_rd < wr_n && exp_idx.size() > 0) begin
            chk("wr_idx", 128'(wr_log[wr_rd % 1024]), 128'(exp_idx.pop_front()));
            wr_rd++;
        end
        wr_rd = wr_n;
        exp_idx.delete();
    endtask

    // ---- bus master ----
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        ack = ~sda_bus;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
            d = {d[6:0], sda_bus};
            tick(Q); scl_m = 1'b0; tick(Q);
        end
        sda_m = ~mack; tick(Q); scl_m = 1'b1; tick(Q);
        oe_ack = sda_oe;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic m_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        write_byte({a, 1'b0}, ack);
        if (a == 7'h18) begin
            chk("addr_ack", 128'(ack), 1);
            chk("busy_on", 128'(busy), 1);
            write_byte(p, ack);
            chk("ptr_ack", 128'(ack), 1);
            mptr = p % NREGS;
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], ack);
                chk("data_ack", 128'(ack), 1);
                exp_idx.push_back(mptr);
                if (mptr != 0) mdl[mptr] = wbuf[i];
                mptr = (mptr + 1) % NREGS;
            end
        end else begin
            chk("addr_nack", 128'(ack), 0);
            write_byte(p, ack);
            chk("ptr_nack", 128'(ack), 0);
        end
        i2c_stop();
        chk("busy_off", 128'(busy), 0);
        chk_wr();
        chk("regs", regs_o, flat());
    endtask

    task automatic m_read(input logic [7:0] p, input int n, input logic setp);
        logic ack, oe;
        logic [7:0] d, e;
        i2c_start();
        if (setp) begin
            write_byte(8'h30, ack); chk("raddr_w_ack", 128'(ack), 1);
            write_byte(p, ack);     chk("rptr_ack", 128'(ack), 1);
            mptr = p % NREGS;
            i2c_start();
        end
        write_byte(8'h31, ack); chk("raddr_r_ack", 128'(ack), 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d, oe);
            e = (mptr == 0) ? in_port : mdl[mptr];
            chk("rdata", 128'(d), 128'(e));
            chk("mack_oe", 128'(oe), 0);
            mptr = (mptr + 1) % NREGS;
        end
        i2c_stop();
        chk("rbusy_off", 128'(busy), 0);
        chk_wr();
    endtask

    initial begin
        int oe0, bz0;
        logic ack;
        for (int i = 0; i < NREGS; i++) mdl[i] = 8'h00;
        mptr = 0;
        tick(4);
        chk("rst_oe", 128'(sda_oe), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_stb", 128'(wr_stb), 0);
        chk("rst_idx", 128'(wr_idx), 0);
        chk("rst_regs", regs_o, 128'h0);
        rst_n = 1'b1;
        tick(10);

        // Write burst
        wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
        m_write(7'h18, 8'h02, 2);
        chk("reg2", 128'(regs_o[23:16]), 128'hAA);
        chk("reg3", 128'(regs_o[31:24]), 128'h55);

        // Pointer set then read of index 0, then read at current pointer (1)
        in_port = 8'h5C;
        m_read(8'h00, 1, 1'b1);
        m_read(8'h00, 1, 1'b0);

        // Address mismatch
        oe0 = oe_cnt; bz0 = busy_cnt;
        m_write(7'h19, 8'h07, 0);
        chk("mis_oe", 128'(oe_cnt - oe0), 0);
        chk("mis_busy", 128'(busy_cnt - bz0), 0);

        // Wrap-around
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        m_write(7'h18, 8'h0F, 3);
        chk("reg15", 128'(regs_o[127:120]), 128'h11);
        chk("reg1", 128'(regs_o[15:8]), 128'h33);
        chk("reg0", 128'(regs_o[7:0]), 128'h00);
        in_port = 8'hA7;
        m_read(8'h0F, 3, 1'b1);

        // STOP after 4 data bits: partial byte discarded, pointer kept
        i2c_start();
        write_byte(8'h30, ack); chk("ab_addr", 128'(ack), 1);
        write_byte(8'h05, ack); chk("ab_ptr", 128'(ack), 1);
        mptr = 5;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk_wr();
        chk("ab_regs", regs_o, flat());
        chk("ab_busy", 128'(busy), 0);
        m_read(8'h00, 1, 1'b0);

        // Randomized bursts
        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            m_write(7'h18, 8'($urandom_range(0, 255)), n);
            in_port = 8'($urandom);
            m_read(8'($urandom_range(0, 255)), $urandom_range(1, 4), 1'b1);
        end
        m_write(7'h18 ^ 7'(1 << $urandom_range(0, 6)), 8'($urandom), 0);

        // Reset asserted while the target holds the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 4);  // 0x30
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        chk("oe_pre_rst", 128'(sda_oe), 1);
        tchk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("oe_rst", 128'(sda_oe), 0);
        tick(2);
        chk("rst2_busy", 128'(busy), 0);
        chk("rst2_stb", 128'(wr_stb), 0);
        chk("rst2_idx", 128'(wr_idx), 0);
        chk("rst2_regs", regs_o, 128'h0);
        for (int i = 0; i < NREGS; i++) mdl[i] = 8'h00;
        mptr = 0;
        scl_m = 1'b0; tick(Q);
        rst_n = 1'b1; tick(Q);
        i2c_stop();
        tchk_en = 1'b1;
        chk_wr();
        in_port = 8'h3E;
        m_read(8'h00, 2, 1'b0);

        chk("scl_hi_oe", 128'(viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
